// File: rtl/rfsoc_dm_cmd_seq.sv
// rfsoc_dm_cmd_seq: splits a capture into AXI DataMover commands, issues them one at a time
// and checks every status beat. Define RFSOC_DM_LOOP_EN for cyclic (DAC playback) re-launch.
module rfsoc_dm_cmd_seq #(
  parameter int MAX_BTT    = 4194304,
  parameter int BEAT_BYTES = 64
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [31:0] start_addr,
  input  logic [31:0] cap_size,
  input  logic        ctl_start,
  input  logic        ctl_reset,
  output logic [71:0] cmd_tdata,
  output logic        cmd_tvalid,
  input  logic        cmd_tready,
  input  logic [7:0]  sts_tdata,
  input  logic        sts_tvalid,
  output logic        sts_tready,
  output logic [31:0] current_addr,
  output logic [7:0]  run_cycles,
  output logic [7:0]  dm_status,
  output logic        dm_err,
  output logic        busy
);

  localparam logic [1:0]  ST_IDLE     = 2'd0;
  localparam logic [1:0]  ST_CMD      = 2'd1;
  localparam logic [1:0]  ST_WAIT_STS = 2'd2;
  localparam logic [1:0]  ST_DRAIN    = 2'd3;
  localparam logic [31:0] MAX_BTT_W   = 32'(MAX_BTT);
  localparam logic [22:0] MAX_BTT_23  = 23'(MAX_BTT);
  localparam logic [31:0] BEAT_MASK   = ~(32'(BEAT_BYTES) - 32'd1);

  function automatic logic [22:0] chunk_len(input logic [31:0] rem);
    if (rem > MAX_BTT_W) begin
      chunk_len = MAX_BTT_23;
    end else begin
      chunk_len = rem[22:0];
    end
  endfunction

  // Status beat {ok,slverr,decerr,interr,tag}: any fault bit or a stale tag is an error.
  function automatic logic sts_bad(input logic [7:0] sts, input logic [3:0] tag);
    sts_bad = !sts[7] || sts[6] || sts[5] || sts[4] || (sts[3:0] != tag);
  endfunction

  logic [1:0]  state_r, state_s;
  logic        start_d_r;
  logic [31:0] rem_r, rem_s;
  logic [31:0] addr_r, addr_s;
  logic [3:0]  tag_r, tag_s;
  logic [7:0]  run_r, run_s;
  logic [7:0]  status_r, status_s;
  logic        err_r, err_s;
  logic [71:0] cmd_tdata_r;
  logic        cmd_tvalid_r;
  logic        sts_tready_r;
  logic        busy_r;

  logic        start_edge_s;
  logic        cmd_hs_s;
  logic        sts_hs_s;
  logic [31:0] launch_rem_s;
  logic [22:0] btt_s;
  logic [22:0] btt_nxt_s;
  logic [31:0] rem_after_s;

  assign start_edge_s = ctl_start & ~start_d_r;
  assign cmd_hs_s     = cmd_tvalid_r & cmd_tready;
  assign sts_hs_s     = sts_tready_r & sts_tvalid;
  assign launch_rem_s = cap_size & BEAT_MASK;
  assign btt_s        = chunk_len(rem_r);
  assign rem_after_s  = rem_r - {9'd0, btt_s};
  assign btt_nxt_s    = chunk_len(rem_s);

  // Next-state and bookkeeping; ctl_reset overrides every other event.
  always_comb begin
    state_s  = state_r;
    rem_s    = rem_r;
    addr_s   = addr_r;
    tag_s    = tag_r;
    run_s    = run_r;
    status_s = status_r;
    err_s    = err_r;
    case (state_r)
      ST_IDLE: begin
        if (!ctl_reset && start_edge_s) begin
          if (launch_rem_s == 32'd0) begin
            err_s = 1'b1;
          end else begin
            rem_s   = launch_rem_s;
            addr_s  = start_addr;
            err_s   = 1'b0;
            state_s = ST_CMD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (cmd_hs_s) begin
          tag_s = tag_r + 4'd1;
        end else begin
          tag_s = tag_r;
        end
        if (ctl_reset) begin
          state_s = cmd_hs_s ? ST_DRAIN : ST_IDLE;
        end else if (cmd_hs_s) begin
          state_s = ST_WAIT_STS;
        end else begin
          state_s = ST_CMD;
        end
      end
      ST_WAIT_STS: begin
        // An abort that coincides with the status beat already consumes it: nothing left to drain.
        if (ctl_reset) begin
          if (sts_hs_s) begin
            status_s = sts_tdata;
            state_s  = ST_IDLE;
          end else begin
            state_s = ST_DRAIN;
          end
        end else if (sts_hs_s) begin
          status_s = sts_tdata;
          if (sts_bad(sts_tdata, cmd_tdata_r[67:64])) begin
            err_s   = 1'b1;
            state_s = ST_IDLE;
          end else begin
            addr_s = addr_r + {9'd0, btt_s};
            rem_s  = rem_after_s;
            if (rem_after_s == 32'd0) begin
              run_s = run_r + 8'd1;
`ifdef RFSOC_DM_LOOP_EN
              if (ctl_start && (launch_rem_s != 32'd0)) begin
                addr_s  = start_addr;
                rem_s   = launch_rem_s;
                state_s = ST_CMD;
              end else begin
                state_s = ST_IDLE;
              end
`else
              state_s = ST_IDLE;
`endif
            end else begin
              state_s = ST_CMD;
            end
          end
        end else begin
          state_s = ST_WAIT_STS;
        end
      end
      ST_DRAIN: begin
        if (sts_hs_s) begin
          status_s = sts_tdata;
          state_s  = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, registered outputs and the command word (loaded only when a command is first offered).
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_r      <= ST_IDLE;
      start_d_r    <= 1'b0;
      rem_r        <= 32'd0;
      addr_r       <= 32'd0;
      tag_r        <= 4'd0;
      run_r        <= 8'd0;
      status_r     <= 8'd0;
      err_r        <= 1'b0;
      cmd_tdata_r  <= 72'd0;
      cmd_tvalid_r <= 1'b0;
      sts_tready_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      start_d_r    <= ctl_start;
      rem_r        <= rem_s;
      addr_r       <= ctl_reset ? 32'd0 : addr_s;
      tag_r        <= tag_s;
      run_r        <= run_s;
      status_r     <= status_s;
      err_r        <= err_s;
      cmd_tvalid_r <= (state_s == ST_CMD);
      sts_tready_r <= (state_s == ST_WAIT_STS) || (state_s == ST_DRAIN);
      busy_r       <= (state_s != ST_IDLE);
      if ((state_s == ST_CMD) && (state_r != ST_CMD)) begin
        cmd_tdata_r <= {4'h0, tag_s, addr_s, 1'b0, 1'b1, 6'd0, 1'b1, btt_nxt_s};
      end
    end
  end

  assign cmd_tdata    = cmd_tdata_r;
  assign cmd_tvalid   = cmd_tvalid_r;
  assign sts_tready   = sts_tready_r;
  assign current_addr = addr_r;
  assign run_cycles   = run_r;
  assign dm_status    = status_r;
  assign dm_err       = err_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_rfsoc_dm_cmd_seq.sv
// Bench for rfsoc_dm_cmd_seq: transaction-level model of the command/status sequencing,
// checked every cycle, plus directed scenarios with literal expectations.
module tb_rfsoc_dm_cmd_seq;
  localparam int MAX_BTT    = 4194304;
  localparam int BEAT_BYTES = 64;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic [31:0] start_addr = 32'd0;
  logic [31:0] cap_size = 32'd0;
  logic        ctl_start = 1'b0;
  logic        ctl_reset = 1'b0;
  logic        cmd_tready = 1'b1;
  logic [7:0]  sts_tdata = 8'd0;
  logic        sts_tvalid = 1'b0;
  logic [71:0] cmd_tdata;
  logic        cmd_tvalid;
  logic        sts_tready;
  logic [31:0] current_addr;
  logic [7:0]  run_cycles;
  logic [7:0]  dm_status;
  logic        dm_err;
  logic        busy;

  always #5 clk = ~clk;

  rfsoc_dm_cmd_seq #(.MAX_BTT(MAX_BTT), .BEAT_BYTES(BEAT_BYTES)) dut (
    .clk(clk), .rstb(rstb), .start_addr(start_addr), .cap_size(cap_size),
    .ctl_start(ctl_start), .ctl_reset(ctl_reset),
    .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready),
    .sts_tdata(sts_tdata), .sts_tvalid(sts_tvalid), .sts_tready(sts_tready),
    .current_addr(current_addr), .run_cycles(run_cycles), .dm_status(dm_status),
    .dm_err(dm_err), .busy(busy)
  );

  typedef struct packed {logic [31:0] addr; logic [31:0] btt;} chunk_t;

  // Model state: pending chunks, one outstanding command, and the register-block view.
  chunk_t      m_q[$];
  logic [71:0] cmd_log[$];
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_out_btt = 32'd0;
  logic [7:0]  m_run = 8'd0;
  logic [7:0]  m_status = 8'd0;
  logic [3:0]  m_tag = 4'd0;
  logic [3:0]  m_out_tag = 4'd0;
  logic        m_err = 1'b0, m_active = 1'b0, m_outst = 1'b0, m_abort = 1'b0, m_prev_start = 1'b0;
  logic        m_chs, m_shs;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [71:0] pack(input logic [31:0] a, input logic [31:0] btt, input logic [3:0] tag);
    return {4'h0, tag, a, 1'b0, 1'b1, 6'h0, 1'b1, btt[22:0]};
  endfunction

  function automatic logic is_bad(input logic [7:0] s, input logic [3:0] tag);
    return (s[7] == 1'b0) || (s[6:4] != 3'd0) || (s[3:0] != tag);
  endfunction

  function automatic void plan(input logic [31:0] base, input logic [31:0] size);
    logic [31:0] left = size & ~32'(BEAT_BYTES - 1);
    logic [31:0] a = base;
    m_q.delete();
    while (left != 32'd0) begin
      chunk_t c;
      c.addr = a;
      c.btt  = (left > 32'(MAX_BTT)) ? 32'(MAX_BTT) : left;
      m_q.push_back(c);
      a    = a + c.btt;
      left = left - c.btt;
    end
  endfunction

  task automatic model_step();
    if (!rstb) begin
      m_q.delete();
      m_addr = 32'd0; m_run = 8'd0; m_status = 8'd0; m_tag = 4'd0; m_out_tag = 4'd0;
      m_err = 1'b0; m_active = 1'b0; m_outst = 1'b0; m_abort = 1'b0; m_prev_start = 1'b0;
    end else begin
      m_chs = cmd_tvalid && cmd_tready;
      m_shs = sts_tvalid && sts_tready;
      if (m_chs) cmd_log.push_back(cmd_tdata);
      if (ctl_reset) begin
        if (m_chs) begin m_out_tag = m_tag; m_tag = m_tag + 4'd1; m_outst = 1'b1; end
        if (m_shs) begin m_status = sts_tdata; m_outst = 1'b0; end
        m_q.delete();
        m_addr = 32'd0;
        m_abort = m_outst;
        m_active = m_outst;
      end else if (!m_active) begin
        if (ctl_start && !m_prev_start) begin
          plan(start_addr, cap_size);
          if (m_q.size() == 0) m_err = 1'b1;
          else begin m_err = 1'b0; m_addr = start_addr; m_active = 1'b1; end
        end
      end else begin
        if (m_chs) begin
          m_out_tag = m_tag; m_out_btt = m_q[0].btt;
          void'(m_q.pop_front());
          m_tag = m_tag + 4'd1; m_outst = 1'b1;
        end
        if (m_shs) begin
          m_status = sts_tdata; m_outst = 1'b0;
          if (m_abort) begin m_abort = 1'b0; m_active = 1'b0; end
          else if (is_bad(sts_tdata, m_out_tag)) begin m_err = 1'b1; m_q.delete(); m_active = 1'b0; end
          else begin
            m_addr = m_addr + m_out_btt;
            if (m_q.size() == 0) begin
              m_run = m_run + 8'd1;
`ifdef RFSOC_DM_LOOP_EN
              if (ctl_start && ((cap_size & ~32'(BEAT_BYTES - 1)) != 32'd0)) begin
                plan(start_addr, cap_size); m_addr = start_addr;
              end else m_active = 1'b0;
`else
              m_active = 1'b0;
`endif
            end
          end
        end
      end
      m_prev_start = ctl_start;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rstb);
    model_step();
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    logic exp_v;
    @(negedge clk);
    exp_v = m_active && !m_outst && (m_q.size() > 0);
    chk("busy", 72'(busy), 72'(m_active));
    chk("cmd_tvalid", 72'(cmd_tvalid), 72'(exp_v));
    if (exp_v) chk("cmd_tdata", cmd_tdata, pack(m_q[0].addr, m_q[0].btt, m_tag));
    chk("sts_tready", 72'(sts_tready), 72'(m_outst));
    chk("current_addr", 72'(current_addr), 72'(m_addr));
    chk("run_cycles", 72'(run_cycles), 72'(m_run));
    chk("dm_err", 72'(dm_err), 72'(m_err));
    chk("dm_status", 72'(dm_status), 72'(m_status));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rstb = 1'b0; ctl_start = 1'b0; ctl_reset = 1'b0; cmd_tready = 1'b1; sts_tvalid = 1'b0;
    cyc(2);
    rstb = 1'b1;
    cyc(1);
    cmd_log.delete();
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] s, input logic hold);
    start_addr = a; cap_size = s; ctl_start = 1'b1;
    cyc(1);
    ctl_start = hold;
  endtask

  task automatic wait_sts_ready();
    int k = 0;
    while (!sts_tready && k < 100) begin cyc(1); k++; end
    chk("sts_ready_timeout", 72'(sts_tready), 72'd1);
  endtask

  task automatic give_sts(input logic [3:0] hi);
    wait_sts_ready();
    if (sts_tready) begin
      sts_tdata = {hi, m_out_tag}; sts_tvalid = 1'b1;
      cyc(1);
      sts_tvalid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 200) begin cyc(1); k++; end
    chk("idle_timeout", 72'(busy), 72'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    do_reset();
    chk("rst_cmd_tdata", cmd_tdata, 72'd0);
    chk("rst_busy", 72'(busy), 72'd0);
    chk("rst_addr", 72'(current_addr), 72'd0);
    chk("rst_run", 72'(run_cycles), 72'd0);

    // single chunk
    launch(32'h1000_0000, 32'h0000_1000, 1'b0);
    chk("single_cmd", cmd_tdata, 72'h00_10000000_40801000);
    give_sts(4'h8);
    wait_idle();
    chk("single_run", 72'(run_cycles), 72'd1);
    chk("single_addr", 72'(current_addr), 72'h1000_1000);
    chk("single_status", 72'(dm_status), 72'h80);

    // split into three commands
    do_reset();
    launch(32'h8000_0000, 32'h0090_0000, 1'b0);
    repeat (3) give_sts(4'h8);
    wait_idle();
    chk("split_count", 72'(cmd_log.size()), 72'd3);
    chk("split_cmd0", cmd_log[0], 72'h00_80000000_40C00000);
    chk("split_cmd1", cmd_log[1], 72'h01_80400000_40C00000);
    chk("split_cmd2", cmd_log[2], 72'h02_80800000_40900000);
    chk("split_addr", 72'(current_addr), 72'h8090_0000);
    chk("split_run", 72'(run_cycles), 72'd1);

    // address wrap, sub-beat size bits ignored
    do_reset();
    launch(32'hFFFF_F000, 32'h0000_2030, 1'b0);
    give_sts(4'h8);
    wait_idle();
    chk("wrap_cmd", cmd_log[0], 72'h00_FFFFF000_40802000);
    chk("wrap_addr", 72'(current_addr), 72'h0000_1000);

    // backpressure
    do_reset();
    cmd_tready = 1'b0;
    launch(32'h0000_4000, 32'h0000_0800, 1'b0);
    chk("bp_first", cmd_tdata, 72'h00_00004000_40800800);
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("bp_valid", 72'(cmd_tvalid), 72'd1);
      chk("bp_data", cmd_tdata, 72'h00_00004000_40800800);
    end
    cmd_tready = 1'b1;
    give_sts(4'h8);
    wait_idle();
    chk("bp_run", 72'(run_cycles), 72'd1);

    // slverr on first of three chunks
    do_reset();
    launch(32'h0100_0000, 32'h0090_0000, 1'b0);
    give_sts(4'h4);
    chk("err_flag", 72'(dm_err), 72'd1);
    chk("err_status", 72'(dm_status), 72'h40);
    chk("err_busy", 72'(busy), 72'd0);
    n = 0;
    repeat (10) begin cyc(1); if (cmd_tvalid) n++; end
    chk("err_no_cmd", 72'(n), 72'd0);
    chk("err_run", 72'(run_cycles), 72'd0);

    // abort in WAIT_STS, drain, relaunch
    do_reset();
    launch(32'h2000_0000, 32'h0000_1000, 1'b0);
    give_sts(4'h8);
    wait_idle();
    launch(32'h2000_0000, 32'h0000_1000, 1'b0);
    wait_sts_ready();
    ctl_reset = 1'b1;
    cyc(1);
    ctl_reset = 1'b0;
    chk("drain_busy", 72'(busy), 72'd1);
    chk("drain_ready", 72'(sts_tready), 72'd1);
    chk("drain_addr", 72'(current_addr), 72'd0);
    give_sts(4'h4);
    chk("drain_status", 72'(dm_status), 72'h41);
    chk("drain_err", 72'(dm_err), 72'd0);
    chk("drain_idle", 72'(busy), 72'd0);
    chk("drain_run", 72'(run_cycles), 72'd1);
    launch(32'h2000_0000, 32'h0000_1000, 1'b0);
    chk("relaunch_cmd", cmd_tdata, 72'h02_20000000_40801000);
    give_sts(4'h8);
    wait_idle();
    chk("relaunch_run", 72'(run_cycles), 72'd2);

    // abort in CMD without handshake; start ignored while ctl_reset held
    do_reset();
    cmd_tready = 1'b0;
    launch(32'h3000_0000, 32'h0000_1000, 1'b0);
    ctl_reset = 1'b1;
    cyc(1);
    chk("abort_cmd_valid", 72'(cmd_tvalid), 72'd0);
    chk("abort_cmd_busy", 72'(busy), 72'd0);
    ctl_start = 1'b1;
    cyc(2);
    chk("abort_start_ignored", 72'(busy), 72'd0);
    ctl_reset = 1'b0; ctl_start = 1'b0; cmd_tready = 1'b1;
    cyc(2);
    chk("abort_log", 72'(cmd_log.size()), 72'd0);

    // abort coinciding with the command handshake -> DRAIN
    do_reset();
    cmd_tready = 1'b0;
    launch(32'h3000_0000, 32'h0000_1000, 1'b0);
    cmd_tready = 1'b1; ctl_reset = 1'b1;
    cyc(1);
    ctl_reset = 1'b0;
    chk("hsabort_ready", 72'(sts_tready), 72'd1);
    chk("hsabort_busy", 72'(busy), 72'd1);
    give_sts(4'h8);
    chk("hsabort_idle", 72'(busy), 72'd0);
    chk("hsabort_status", 72'(dm_status), 72'h80);
    chk("hsabort_run", 72'(run_cycles), 72'd0);

    // zero-length launch, then a valid launch clears dm_err
    do_reset();
    launch(32'h1000_0000, 32'h0000_003F, 1'b0);
    chk("zero_err", 72'(dm_err), 72'd1);
    chk("zero_busy", 72'(busy), 72'd0);
    cyc(5);
    chk("zero_no_cmd", 72'(cmd_log.size()), 72'd0);
    launch(32'h1000_0000, 32'h0000_0040, 1'b0);
    chk("zero_clear", 72'(dm_err), 72'd0);
    give_sts(4'h8);
    wait_idle();

`ifdef RFSOC_DM_LOOP_EN
    // cyclic playback while start is held
    do_reset();
    launch(32'h5000_0000, 32'h0000_1000, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      give_sts(4'h8);
      chk("loop_run", 72'(run_cycles), 72'(i));
      chk("loop_busy", 72'(busy), 72'd1);
    end
    ctl_start = 1'b0;
    give_sts(4'h8);
    wait_idle();
    chk("loop_final_run", 72'(run_cycles), 72'd4);
    for (int i = 0; i < 4; i++) chk("loop_addr", 72'(cmd_log[i][63:32]), 72'h5000_0000);
`endif

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
